rom_data_proc: RTL and testbench

Upstream stage of the ROM-data display path: on a start request it scans a 16-entry, 8-bit ROM sequentially and computes sum, min/max, average and an above-threshold count. It presents the selected result as a registered 16-bit word `val`, which drives the `val` input of the downstream 4-digit 7-segment display driver directly.

---
 rtl/rom_data_proc_pkg.sv | 9 +
 rtl/rom_data_proc_if.sv | 10 +
 rtl/rom_data_proc_rom16x8.sv | 23 ++
 rtl/rom_data_proc.sv | 79 +++++++
 tb/tb_rom_data_proc.sv | 126 ++++++++++++
 5 files changed

// File: rtl/rom_data_proc_pkg.sv
// rom_data_proc_pkg: shared sizes, threshold, FSM state and result-select encodings
package rom_data_proc_pkg;
  localparam int DEPTH = 16;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam logic [7:0] THRESH = 8'h80;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;
  typedef enum logic [1:0] {SEL_SUM = 2'd0, SEL_MINMAX = 2'd1, SEL_AVG = 2'd2, SEL_CNT = 2'd3} sel_t;
endpackage

// File: rtl/rom_data_proc_if.sv
// rom_data_proc_if: request/result bundle (start, sel in; val, busy, done out)
interface rom_data_proc_if;
  logic        start;
  logic [1:0]  sel;
  logic [15:0] val;
  logic        busy;
  logic        done;
  modport master (output start, sel, input val, busy, done);
  modport slave (input start, sel, output val, busy, done);
endinterface

// File: rtl/rom_data_proc_rom16x8.sv
// rom16x8: synchronous-read ROM; ports clk, addr, data; FILL_EN forces every entry to FILL
module rom16x8 #(
  parameter int AW = 4,
  parameter int DW = 8,
  parameter bit FILL_EN = 1'b0,
  parameter logic [DW-1:0] FILL = '0
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] data
);
  logic [DW-1:0] tbl;
  always_comb
    case (addr)
      4'h0: tbl = 8'h00; 4'h1: tbl = 8'h11; 4'h2: tbl = 8'h22; 4'h3: tbl = 8'h33;
      4'h4: tbl = 8'h44; 4'h5: tbl = 8'h55; 4'h6: tbl = 8'h66; 4'h7: tbl = 8'h77;
      4'h8: tbl = 8'h88; 4'h9: tbl = 8'h99; 4'hA: tbl = 8'hAA; 4'hB: tbl = 8'hBB;
      4'hC: tbl = 8'hCC; 4'hD: tbl = 8'hDD; 4'hE: tbl = 8'hEE;
      default: tbl = 8'hFF;
    endcase
  always_ff @(posedge clk)
    data <= FILL_EN ? FILL : tbl;
endmodule

// File: rtl/rom_data_proc.sv
// rom_data_proc: scans a 16x8 ROM and reports sum, {min,max}, average or above-threshold count
// Ports: clk, rst (async, active low), bus (slave: start, sel in; val, busy, done out)
module rom_data_proc
  import rom_data_proc_pkg::*;
#(
  parameter bit FILL_EN = 1'b0,
  parameter logic [7:0] FILL = 8'h00
) (
  input  logic clk,
  input  logic rst,
  rom_data_proc_if.slave bus
);
  state_t        state;
  logic [AW-1:0] addr;
  logic [DW-1:0] d;
  logic          rd_valid;
  logic [11:0]   sum, r_sum;
  logic [7:0]    mn, mx, r_min, r_max;
  logic [4:0]    cnt, r_cnt;
  rom16x8 #(.AW(AW), .DW(DW), .FILL_EN(FILL_EN), .FILL(FILL)) u_rom (.clk(clk), .addr(addr), .data(d));
  // rd_valid follows RUN by one edge so it lines up with the synchronous ROM output
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      addr <= '0;
      rd_valid <= 1'b0;
      sum <= '0;
      mn <= '0;
      mx <= '0;
      cnt <= '0;
      r_sum <= '0;
      r_min <= '0;
      r_max <= '0;
      r_cnt <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      rd_valid <= state == RUN;
      bus.done <= 1'b0;
      if (rd_valid) begin
        sum <= sum + {4'h0, d};
        mn <= d < mn ? d : mn;
        mx <= d > mx ? d : mx;
        cnt <= cnt + {4'h0, d > THRESH};
      end
      case (state)
        IDLE: if (bus.start) begin
          state <= RUN;
          addr <= '0;
          sum <= '0;
          mn <= 8'hFF;
          mx <= '0;
          cnt <= '0;
          bus.busy <= 1'b1;
        end
        RUN: begin
          addr <= addr + 1'b1;
          if (addr == AW'(DEPTH - 1)) state <= DRAIN;
        end
        DRAIN: state <= DONE;
        DONE: begin
          r_sum <= sum;
          r_min <= mn;
          r_max <= mx;
          r_cnt <= cnt;
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  // val muxes the result registers, never the live accumulators
  always_ff @(posedge clk or negedge rst)
    if (!rst) bus.val <= '0;
    else bus.val <= bus.sel == SEL_SUM ? {4'h0, r_sum} :
                    bus.sel == SEL_MINMAX ? {r_min, r_max} :
                    bus.sel == SEL_AVG ? {8'h00, 8'(r_sum >> AW)} : {11'h0, r_cnt};
endmodule

// File: tb/tb_rom_data_proc.sv
// tb_rom_data_proc: directed self-checking bench for rom_data_proc (default and all-0x80 ROM)
module tb_rom_data_proc;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  rom_data_proc_if bus();
  rom_data_proc_if bus2();
  rom_data_proc dut (.clk(clk), .rst(rst), .bus(bus));
  rom_data_proc #(.FILL_EN(1'b1), .FILL(8'h80)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic scan(input logic [15:0] exp);
    int b = 0;
    int d = 0;
    int at = -1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("busy_e0", {15'h0, bus.busy}, 16'h1);
    for (int e = 0; e < 19; e++) begin
      if (e > 0) step();
      b += int'(bus.busy);
      if (bus.done) begin
        d++;
        at = e;
      end
    end
    check("busy_cycles", 16'(b), 16'd18);
    check("done_pulses", 16'(d), 16'd1);
    check("done_edge", 16'(at), 16'd18);
    step();
    check("done_clear", {15'h0, bus.done}, 16'h0);
    check("scan_val", bus.val, exp);
  endtask
  initial begin
    int d;
    int dn;
    logic [15:0] exp_sel [4];
    logic [15:0] exp_flat [4];
    exp_sel = '{16'h07F8, 16'h00FF, 16'h007F, 16'h0008};
    exp_flat = '{16'h0800, 16'h8080, 16'h0080, 16'h0000};
    bus.start = 1'b0;
    bus.sel = 2'd0;
    bus2.start = 1'b0;
    bus2.sel = 2'd0;
    step(3);
    rst = 1'b1;
    d = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      d += int'(bus.done);
    end
    check("idle_val", bus.val, 16'h0000);
    check("idle_busy", {15'h0, bus.busy}, 16'h0);
    check("idle_done", 16'(d), 16'h0);
    check("idle_addr", {12'h0, dut.addr}, 16'h0);
    scan(16'h07F8);
    for (int s = 1; s < 4; s++) begin
      bus.sel = 2'(s);
      #1;
      check("sel_hold", bus.val, exp_sel[s-1]);
      step();
      check("sel_val", bus.val, exp_sel[s]);
    end
    bus.sel = 2'd0;
    step();
    bus.start = 1'b1;
    dn = 0;
    for (int e = 0; e < 58; e++) begin
      step();
      if (bus.done) begin
        check("b2b_done_edge", 16'(e), 16'(18 + 19 * dn));
        dn++;
      end
      if (e > 0 && e % 19 == 0) check("b2b_val", bus.val, 16'h07F8);
    end
    check("b2b_dones", 16'(dn), 16'd3);
    bus.start = 1'b0;
    step(20);
    check("b2b_idle", {15'h0, bus.busy}, 16'h0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step(8);
    rst = 1'b0;
    #1;
    check("rst_busy", {15'h0, bus.busy}, 16'h0);
    check("rst_val", bus.val, 16'h0000);
    step(2);
    rst = 1'b1;
    d = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      d += int'(bus.done);
    end
    check("post_rst_done", 16'(d), 16'h0);
    check("post_rst_val", bus.val, 16'h0000);
    check("post_rst_busy", {15'h0, bus.busy}, 16'h0);
    scan(16'h07F8);
    bus2.start = 1'b1;
    step();
    bus2.start = 1'b0;
    step(19);
    check("flat_busy", {15'h0, bus2.busy}, 16'h0);
    for (int s = 0; s < 4; s++) begin
      bus2.sel = 2'(s);
      step();
      check("flat_val", bus2.val, exp_flat[s]);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
